// File: rtl/ahb_master_arbiter.sv
// Two-master AHB arbiter: grants the address phase round-robin, muxes address/control
// by the address owner and write data by the data owner, and gates HREADY/HRESP back.
module ahb_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] m0_HADDR,
    input  logic [1:0]            m0_HTRANS,
    input  logic                  m0_HWRITE,
    input  logic [2:0]            m0_HSIZE,
    input  logic [2:0]            m0_HBURST,
    input  logic [3:0]            m0_HPROT,
    input  logic                  m0_HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] m0_HWDATA,
    output logic                  m0_HREADY,
    output logic                  m0_HRESP,
    output logic [DATA_WIDTH-1:0] m0_HRDATA,
    input  logic [ADDR_WIDTH-1:0] m1_HADDR,
    input  logic [1:0]            m1_HTRANS,
    input  logic                  m1_HWRITE,
    input  logic [2:0]            m1_HSIZE,
    input  logic [2:0]            m1_HBURST,
    input  logic [3:0]            m1_HPROT,
    input  logic                  m1_HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] m1_HWDATA,
    output logic                  m1_HREADY,
    output logic                  m1_HRESP,
    output logic [DATA_WIDTH-1:0] m1_HRDATA,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic [1:0]            hgrant,
    output logic                  hmaster
);

    localparam logic       DEF_MASTER    = 1'(DEFAULT_MASTER);
    localparam logic [1:0] TRANS_IDLE    = 2'b00;
    localparam logic [1:0] TRANS_BUSY    = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ  = 2'b10;
    localparam logic [1:0] TRANS_SEQ     = 2'b11;
    localparam logic [2:0] BURST_SINGLE  = 3'b000;

    logic addr_owner_q, addr_owner_d;
    logic data_owner_q, data_owner_d;
    logic data_active_q, data_active_d;
    logic last_grant_q, last_grant_d;

    logic [1:0] req;
    logic       switch_blocked;
    logic       rr_last;
    logic       next_owner;

    always_comb begin
        HADDR     = addr_owner_q ? m1_HADDR     : m0_HADDR;
        HTRANS    = addr_owner_q ? m1_HTRANS    : m0_HTRANS;
        HWRITE    = addr_owner_q ? m1_HWRITE    : m0_HWRITE;
        HSIZE     = addr_owner_q ? m1_HSIZE     : m0_HSIZE;
        HBURST    = addr_owner_q ? m1_HBURST    : m0_HBURST;
        HPROT     = addr_owner_q ? m1_HPROT     : m0_HPROT;
        HMASTLOCK = addr_owner_q ? m1_HMASTLOCK : m0_HMASTLOCK;
        HWDATA    = data_owner_q ? m1_HWDATA    : m0_HWDATA;
    end

    always_comb begin
        req = {m1_HTRANS[1], m0_HTRANS[1]};
        switch_blocked = (HTRANS == TRANS_SEQ) || (HTRANS == TRANS_BUSY) ||
                         ((HTRANS == TRANS_NONSEQ) && (HBURST != BURST_SINGLE)) ||
                         (HMASTLOCK && (HTRANS != TRANS_IDLE));
        // A transfer completing this cycle counts as the latest grant, so contention alternates.
        rr_last = HTRANS[1] ? addr_owner_q : last_grant_q;
        if (switch_blocked) begin
            next_owner = addr_owner_q;
        end else if (req == 2'b11) begin
            next_owner = ~rr_last;
        end else if (req[0]) begin
            next_owner = 1'b0;
        end else if (req[1]) begin
            next_owner = 1'b1;
        end else begin
            next_owner = DEF_MASTER;
        end
    end

    always_comb begin
        addr_owner_d  = addr_owner_q;
        data_owner_d  = data_owner_q;
        data_active_d = data_active_q;
        last_grant_d  = last_grant_q;
        if (HREADY) begin
            data_owner_d  = addr_owner_q;
            data_active_d = HTRANS[1];
            addr_owner_d  = next_owner;
            if (HTRANS[1]) begin
                last_grant_d = addr_owner_q;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner_q  <= DEF_MASTER;
            data_owner_q  <= DEF_MASTER;
            data_active_q <= 1'b0;
            last_grant_q  <= DEF_MASTER;
        end else begin
            addr_owner_q  <= addr_owner_d;
            data_owner_q  <= data_owner_d;
            data_active_q <= data_active_d;
            last_grant_q  <= last_grant_d;
        end
    end

    always_comb begin
        hgrant    = addr_owner_q ? 2'b10 : 2'b01;
        hmaster   = addr_owner_q;
        m0_HRDATA = HRDATA;
        m1_HRDATA = HRDATA;
        m0_HREADY = HREADY & (~addr_owner_q | (data_active_q & ~data_owner_q));
        m1_HREADY = HREADY & ( addr_owner_q | (data_active_q &  data_owner_q));
        m0_HRESP  = HRESP & data_active_q & ~data_owner_q;
        m1_HRESP  = HRESP & data_active_q &  data_owner_q;
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the arbitration rules.
module tb_ahb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr  [2];
    logic [1:0]  trans [2];
    logic        write [2];
    logic [2:0]  size  [2];
    logic [2:0]  burst [2];
    logic [3:0]  prot  [2];
    logic        lock  [2];
    logic [31:0] wdata [2];
    logic        m0_ready, m1_ready, m0_resp, m1_resp;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hmastlock, hready, hresp, hmaster;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  hgrant;

    int tests_run = 0;
    int failures  = 0;

    // Reference model: who owns the address phase, who owns the data phase, last winner
    int model_own, model_down, model_last;
    bit model_dact;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEFAULT_MASTER(0)) dut (
        .HCLK(clk), .HRESETn(rst_n),
        .m0_HADDR(addr[0]), .m0_HTRANS(trans[0]), .m0_HWRITE(write[0]), .m0_HSIZE(size[0]),
        .m0_HBURST(burst[0]), .m0_HPROT(prot[0]), .m0_HMASTLOCK(lock[0]), .m0_HWDATA(wdata[0]),
        .m0_HREADY(m0_ready), .m0_HRESP(m0_resp), .m0_HRDATA(m0_rdata),
        .m1_HADDR(addr[1]), .m1_HTRANS(trans[1]), .m1_HWRITE(write[1]), .m1_HSIZE(size[1]),
        .m1_HBURST(burst[1]), .m1_HPROT(prot[1]), .m1_HMASTLOCK(lock[1]), .m1_HWDATA(wdata[1]),
        .m1_HREADY(m1_ready), .m1_HRESP(m1_resp), .m1_HRDATA(m1_rdata),
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HRDATA(hrdata),
        .HREADY(hready), .HRESP(hresp), .hgrant(hgrant), .hmaster(hmaster)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic [1:0] t, input logic [2:0] b,
                                 input logic lk, input logic [31:0] a, input logic w,
                                 input logic [31:0] wd);
        trans[m] = t;  burst[m] = b; lock[m] = lk;
        addr[m]  = a;  write[m] = w; wdata[m] = wd;
        size[m]  = 3'b010; prot[m] = 4'h3;
    endtask

    function automatic void model_reset();
        model_own  = 0;
        model_down = 0;
        model_last = 0;
        model_dact = 0;
    endfunction

    function automatic int model_next_owner();
        int  t       = int'(trans[model_own]);
        bit  in_burst = (t == 3) || (t == 1) || (t == 2 && burst[model_own] != 3'b000);
        bit  locked   = lock[model_own] && t != 0;
        bit  r0       = trans[0] >= 2'b10;
        bit  r1       = trans[1] >= 2'b10;
        int  latest   = (t >= 2) ? model_own : model_last;
        if (in_burst || locked) return model_own;
        if (r0 && r1)           return 1 - latest;
        if (r0)                 return 0;
        if (r1)                 return 1;
        return 0;
    endfunction

    // Compare every bus-facing output against what the model says this cycle should show
    task automatic check_cycle();
        bit exp_r0, exp_r1;
        @(negedge clk);
        exp_r0 = hready && (model_own == 0 || (model_dact && model_down == 0));
        exp_r1 = hready && (model_own == 1 || (model_dact && model_down == 1));
        checkOutput("hgrant",  64'(hgrant),   64'(model_own == 1 ? 2'b10 : 2'b01));
        checkOutput("hmaster", 64'(hmaster),  64'(model_own));
        checkOutput("haddr",   64'(haddr),    64'(addr[model_own]));
        checkOutput("htrans",  64'(htrans),   64'(trans[model_own]));
        checkOutput("hwrite",  64'(hwrite),   64'(write[model_own]));
        checkOutput("hburst",  64'(hburst),   64'(burst[model_own]));
        checkOutput("hlock",   64'(hmastlock),64'(lock[model_own]));
        checkOutput("hwdata",  64'(hwdata),   64'(wdata[model_down]));
        checkOutput("m0_ready",64'(m0_ready), 64'(exp_r0));
        checkOutput("m1_ready",64'(m1_ready), 64'(exp_r1));
        checkOutput("m0_resp", 64'(m0_resp),  64'(hresp && model_dact && model_down == 0));
        checkOutput("m1_resp", 64'(m1_resp),  64'(hresp && model_dact && model_down == 1));
        checkOutput("m0_rdata",64'(m0_rdata), 64'(hrdata));
        checkOutput("m1_rdata",64'(m1_rdata), 64'(hrdata));
    endtask

    task automatic advance();
        int  nxt_own  = model_own;
        int  nxt_down = model_down;
        int  nxt_last = model_last;
        bit  nxt_dact = model_dact;
        if (hready) begin
            nxt_own  = model_next_owner();
            nxt_down = model_own;
            nxt_dact = trans[model_own][1];
            if (trans[model_own][1]) nxt_last = model_own;
        end
        @(posedge clk);
        #1;
        model_own = nxt_own; model_down = nxt_down; model_last = nxt_last; model_dact = nxt_dact;
    endtask

    task automatic do_reset();
        applyStimulus(0, 2'b00, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1, 2'b00, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
        hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_hgrant",   64'(hgrant),   64'(2'b01));
        checkOutput("rst_htrans",   64'(htrans),   64'(2'b00));
        checkOutput("rst_m1_ready", 64'(m1_ready), 64'(1'b0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        #2;
        do_reset();
        check_cycle();
        advance();

        // DMA single read at 0x2000_0000
        applyStimulus(1, 2'b10, 3'b000, 1'b0, 32'h2000_0000, 1'b0, 32'h0);
        check_cycle();
        checkOutput("dma_wait_ready", 64'(m1_ready), 64'(1'b0));
        advance();
        check_cycle();
        checkOutput("dma_grant", 64'(hgrant), 64'(2'b10));
        checkOutput("dma_haddr", 64'(haddr),  64'(32'h2000_0000));
        advance();
        applyStimulus(1, 2'b00, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
        hrdata = 32'hCAFE_F00D;
        check_cycle();
        checkOutput("dma_rdata", 64'(m1_rdata), 64'(32'hCAFE_F00D));
        checkOutput("dma_ready", 64'(m1_ready), 64'(1'b1));
        advance();

        // Contention: both masters issue NONSEQ singles back to back
        do_reset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 2'b10, 3'b000, 1'b0, 32'h1000 + 32'(k), 1'b1, 32'hA000 + 32'(k));
            applyStimulus(1, 2'b10, 3'b000, 1'b0, 32'h2000 + 32'(k), 1'b1, 32'hB000 + 32'(k));
            check_cycle();
            checkOutput("rr_grant", 64'(hgrant), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            advance();
        end

        // INCR4 burst from m0 must not be interrupted by m1's request
        do_reset();
        applyStimulus(1, 2'b10, 3'b000, 1'b0, 32'h4000, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, (k == 0) ? 2'b10 : (k < 4 ? 2'b11 : 2'b00), 3'b011, 1'b0,
                          32'h100 + 32'(4 * k), 1'b0, 32'h0);
            check_cycle();
            checkOutput("burst_hgrant",   64'(hgrant),   64'(2'b01));
            checkOutput("burst_m1_ready", 64'(m1_ready), 64'(1'b0));
            advance();
        end
        check_cycle();
        checkOutput("burst_handover", 64'(hgrant), 64'(2'b10));
        advance();

        // m1 write followed by three wait states while m0 requests
        do_reset();
        applyStimulus(1, 2'b10, 3'b000, 1'b0, 32'h3000, 1'b1, 32'h0000_AAAA);
        repeat (2) begin check_cycle(); advance(); end
        applyStimulus(1, 2'b00, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0000_AAAA);
        applyStimulus(0, 2'b10, 3'b000, 1'b0, 32'h5000, 1'b0, 32'h0);
        hready = 1'b0;
        repeat (3) begin
            check_cycle();
            checkOutput("wait_hgrant",   64'(hgrant),   64'(2'b10));
            checkOutput("wait_hwdata",   64'(hwdata),   64'(32'h0000_AAAA));
            checkOutput("wait_m0_ready", 64'(m0_ready), 64'(1'b0));
            advance();
        end
        hready = 1'b1;
        check_cycle();
        advance();

        // Locked m0 traffic holds the bus, then reset lands mid-transfer
        do_reset();
        applyStimulus(0, 2'b10, 3'b000, 1'b1, 32'h6000, 1'b0, 32'h0);
        applyStimulus(1, 2'b10, 3'b000, 1'b0, 32'h7000, 1'b0, 32'h0);
        repeat (4) begin
            check_cycle();
            checkOutput("lock_hgrant", 64'(hgrant), 64'(2'b01));
            advance();
        end
        hresp = 1'b1;
        check_cycle();
        checkOutput("lock_resp", 64'(m0_resp), 64'(1'b1));
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_hgrant", 64'(hgrant),  64'(2'b01));
        checkOutput("async_dact",   64'(m0_resp), 64'(1'b0));
        @(posedge clk);
        #1;
        do_reset();

        // Randomized traffic, with a mid-traffic reset every so often
        for (int n = 0; n < 800; n++) begin
            for (int m = 0; m < 2; m++) begin
                applyStimulus(m, 2'($urandom_range(0, 3)),
                              ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7)),
                              ($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 1)),
                              $urandom);
            end
            hready = ($urandom_range(0, 3) != 0);
            hresp  = ($urandom_range(0, 7) == 0);
            hrdata = $urandom;
            check_cycle();
            advance();
            if (n % 200 == 199) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
